// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter
//   Shares a single-ported, combinational-read instruction ROM between the
//   IF-stage fetch (master 0) and a debug/boot-loader read port (master 1).
//   Fetch has fixed priority. A starvation counter hands the ROM to debug
//   after STARVE_LIMIT consecutive debug denials. Read data is registered
//   with one cycle of latency.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   m0_req/m0_addr        fetch request and byte address
//   m0_gnt                fetch granted this cycle (combinational)
//   m0_rvalid/m0_rdata    fetch response (registered)
//   m1_req/m1_addr        debug request and byte address
//   m1_gnt                debug granted this cycle (combinational)
//   m1_rvalid/m1_rdata    debug response (registered)
//   m1_err                debug misaligned-address error, valid with m1_rvalid
//   rom_ce/rom_addr       ROM chip enable and byte address
//   rom_inst              ROM combinational read data
//   stallreq_if           fetch stall request (fetch requesting but denied)
module inst_rom_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_inst,
   output logic              stallreq_if
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              m0_rvalid_q, m1_rvalid_q, m1_err_q;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              starve_win;
   logic              m1_misaligned;

   assign m1_misaligned = (m1_addr[1:0] != 2'b00);
   // With LIMIT==0 the counter never leaves 0, so debug always wins.
   assign starve_win    = (starve_cnt_q == LIMIT) && m1_req;

   // Arbitration and ROM drive; everything is forced idle during reset.
   always_comb begin
      m0_gnt      = 1'b0;
      m1_gnt      = 1'b0;
      rom_addr    = '0;
      rom_ce      = 1'b0;
      stallreq_if = 1'b0;
      if (!rst) begin
         if (starve_win) begin
            m1_gnt = 1'b1;
         end else if (m0_req) begin
            m0_gnt = 1'b1;
         end else if (m1_req) begin
            m1_gnt = 1'b1;
         end
         if (m0_gnt) begin
            rom_addr = m0_addr;
         end else if (m1_gnt) begin
            rom_addr = m1_addr;
         end
         // A misaligned debug grant is answered locally, the ROM stays idle.
         rom_ce      = m0_gnt | (m1_gnt & ~m1_misaligned);
         stallreq_if = m0_req & ~m0_gnt;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (m1_gnt || !m1_req) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_comb begin
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      if (m0_gnt) begin
         m0_rdata_d = rom_inst;
      end
      if (m1_gnt) begin
         m1_rdata_d = m1_misaligned ? '0 : rom_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         m0_rvalid_q  <= 1'b0;
         m1_rvalid_q  <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         m0_rvalid_q  <= m0_gnt;
         m1_rvalid_q  <= m1_gnt;
         m1_err_q     <= m1_gnt & m1_misaligned;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   assign m0_rvalid = m0_rvalid_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rvalid = m1_rvalid_q;
   assign m1_rdata  = m1_rdata_q;
   assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Testbench for inst_rom_arbiter: directed scenarios plus a randomized run,
// all checked against a behavioural model of the arbitration rules.
module tb_inst_rom_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m1_req;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m1_err;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, rom_inst;
   logic              rom_ce, stallreq_if;
   logic [ADDR_W-1:0] rom_addr;

   logic [DATA_W-1:0] rom_mem [256];
   assign rom_inst = rom_mem[rom_addr[9:2]];

   always #5 clk = ~clk;

   inst_rom_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
      .stallreq_if(stallreq_if)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state: consecutive debug denials (unbounded) and
   // the responses the ROM port should present after each edge.
   int                denials = 0;
   logic              e_g0, e_g1, e_ce, e_stall, e_mis;
   logic [ADDR_W-1:0] e_addr;
   logic              r0v = 1'b0, r1v = 1'b0, r1e = 1'b0;
   logic [DATA_W-1:0] r0d = '0, r1d = '0;

   wire [ADDR_W+3:0]     act_comb = {m0_gnt, m1_gnt, rom_ce, stallreq_if, rom_addr};
   wire [2*DATA_W+2:0]   act_resp = {m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, m1_err};
   logic [ADDR_W+3:0]    exp_comb;
   logic [2*DATA_W+2:0]  exp_resp;

   task automatic predict();
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (!rst) begin
         if (m1_req && denials >= STARVE_LIMIT) e_g1 = 1'b1;
         else if (m0_req)                       e_g0 = 1'b1;
         else if (m1_req)                       e_g1 = 1'b1;
      end
      e_mis    = (m1_addr % 4) != 0;
      e_ce     = e_g0 | (e_g1 & !e_mis);
      e_addr   = e_g0 ? m0_addr : (e_g1 ? m1_addr : '0);
      e_stall  = !rst && m0_req && !e_g0;
      exp_comb = {e_g0, e_g1, e_ce, e_stall, e_addr};
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      if (rst) begin
         r0v = 1'b0; r0d = '0; r1v = 1'b0; r1d = '0; r1e = 1'b0;
         denials = 0;
      end else begin
         r0v = e_g0;
         if (e_g0) r0d = rom_mem[(m0_addr / 4) % 256];
         r1v = e_g1;
         r1e = e_g1 && e_mis;
         if (e_g1) r1d = e_mis ? '0 : rom_mem[(m1_addr / 4) % 256];
         if (m1_req && !e_g1) denials++;
         else                 denials = 0;
      end
      exp_resp = {r0v, r0d, r1v, r1d, r1e};
      #1;
   endtask

   function automatic int exp_cnt();
      return (denials > STARVE_LIMIT) ? STARVE_LIMIT : denials;
   endfunction

   task automatic drive(input logic r, input logic q0, input logic [ADDR_W-1:0] a0,
                        input logic q1, input logic [ADDR_W-1:0] a1);
      rst = r; m0_req = q0; m0_addr = a0; m1_req = q1; m1_addr = a1;
      #1;
      predict();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
         checks++;
         if (act_comb !== exp_comb || m0_gnt !== 1'b0 || rom_ce !== 1'b0) begin
            errors++; $display("FAIL reset_comb cyc%0d: got %h want %h", i, act_comb, exp_comb);
         end
         tick();
         checks++;
         if (act_resp !== exp_resp || m0_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_resp cyc%0d: got %h want %h", i, act_resp, exp_resp);
         end
      end
      drive(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
      checks++;
      if (act_comb !== exp_comb || m0_gnt !== 1'b1 || rom_addr !== 32'h0) begin
         errors++; $display("FAIL reset_first_gnt: got %h want %h", act_comb, exp_comb);
      end
      tick();
      checks++;
      if (act_resp !== exp_resp || m0_rvalid !== 1'b1 || m0_rdata !== rom_mem[0]) begin
         errors++; $display("FAIL reset_first_resp: got %h want %h", act_resp, exp_resp);
      end
   endtask

   task automatic test_fetch_stream();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'(4 * i), 1'b0, 32'h0);
         checks++;
         if (act_comb !== exp_comb || m0_gnt !== 1'b1 || stallreq_if !== 1'b0) begin
            errors++; $display("FAIL fetch_comb %0d: got %h want %h", i, act_comb, exp_comb);
         end
         tick();
         checks++;
         if (act_resp !== exp_resp || m0_rvalid !== 1'b1 || m0_rdata !== rom_mem[i]) begin
            errors++; $display("FAIL fetch_resp %0d: got %h want %h", i, act_resp, exp_resp);
         end
      end
   endtask

   task automatic test_starvation();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, 32'(4 * i), 1'b1, 32'h10);
         checks++;
         if (act_comb !== exp_comb || m1_gnt !== (i == 4) || stallreq_if !== (i == 4)) begin
            errors++; $display("FAIL starve_comb %0d: got %h want %h", i, act_comb, exp_comb);
         end
         tick();
         checks++;
         if (act_resp !== exp_resp || dut.starve_cnt_q !== CNT_W'(exp_cnt())) begin
            errors++; $display("FAIL starve_resp %0d: got %h cnt %0d want %h cnt %0d",
                               i, act_resp, dut.starve_cnt_q, exp_resp, exp_cnt());
         end
         if (i == 4) begin
            checks++;
            if (m1_rvalid !== 1'b1 || m1_rdata !== rom_mem[4]) begin
               errors++; $display("FAIL starve_m1_data: got %b/%h want 1/%h", m1_rvalid, m1_rdata, rom_mem[4]);
            end
         end
      end
   endtask

   task automatic test_misaligned();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h6);
      checks++;
      if (act_comb !== exp_comb || m1_gnt !== 1'b1 || rom_ce !== 1'b0) begin
         errors++; $display("FAIL misalign_comb: got %h want %h", act_comb, exp_comb);
      end
      tick();
      checks++;
      if (act_resp !== exp_resp || m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== '0) begin
         errors++; $display("FAIL misalign_resp: got %h want %h", act_resp, exp_resp);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h8);
      tick();
      checks++;
      if (act_resp !== exp_resp || m1_err !== 1'b0) begin
         errors++; $display("FAIL aligned_err_clear: got %h want %h", act_resp, exp_resp);
      end
   endtask

   task automatic test_retraction();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 32'h40, (i < 2), 32'h20);
         checks++;
         if (act_comb !== exp_comb || m1_gnt !== 1'b0) begin
            errors++; $display("FAIL retract_comb %0d: got %h want %h", i, act_comb, exp_comb);
         end
         tick();
         checks++;
         if (act_resp !== exp_resp || m1_rvalid !== 1'b0
             || dut.starve_cnt_q !== CNT_W'(i < 2 ? i + 1 : 0)) begin
            errors++; $display("FAIL retract_resp %0d: got %h cnt %0d want %h",
                               i, act_resp, dut.starve_cnt_q, exp_resp);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h24);
      tick();
      drive(1'b0, 1'b1, 32'h24, 1'b1, 32'h24);
      checks++;
      if (m0_gnt !== 1'b1) begin
         errors++; $display("FAIL midrst_pre_gnt: got %b want 1", m0_gnt);
      end
      rst = 1'b1;
      #1;
      tick();
      checks++;
      if (act_resp !== exp_resp || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0
          || dut.starve_cnt_q !== '0) begin
         errors++; $display("FAIL midrst_resp: got %h cnt %0d want %h",
                            act_resp, dut.starve_cnt_q, exp_resp);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)) << 2,
               1'($urandom_range(0, 2) != 0), 32'($urandom_range(0, 1023)));
         checks++;
         if (act_comb !== exp_comb) begin
            errors++; $display("FAIL rand_comb %0d: got %h want %h", i, act_comb, exp_comb);
         end
         tick();
         checks++;
         if (act_resp !== exp_resp || dut.starve_cnt_q !== CNT_W'(exp_cnt())) begin
            errors++; $display("FAIL rand_resp %0d: got %h cnt %0d want %h cnt %0d",
                               i, act_resp, dut.starve_cnt_q, exp_resp, exp_cnt());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
      test_reset();
      test_fetch_stream();
      test_starvation();
      test_misaligned();
      test_retraction();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule

// File: doc/inst_rom_arbiter.md
Name: inst_rom_arbiter

Overview:
- Shares the single-ported, combinational-read instruction ROM between two requesters:
  - Master 0: IF-stage fetch.
  - Master 1: debug/boot-loader read port.
- Owns the ROM chip-enable and address; returns registered read data with one cycle of latency.
- Fetch has fixed priority. A starvation counter forces a debug grant after a bounded number of denials.
- Raises a fetch stall request to the pipeline controller whenever fetch is denied.

Parameters:
- ADDR_W, 32, width of request and ROM addresses.
- DATA_W, 32, instruction word width.
- STARVE_LIMIT, 4, number of consecutive m1 denials after which m1 wins the next arbitration.
- CNT_W, 3, starvation counter width; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  fetch read request.
- m0_addr  in  ADDR_W  fetch byte address.
- m0_gnt  out  1  fetch granted this cycle (combinational).
- m0_rvalid  out  1  fetch read data valid (registered).
- m0_rdata  out  DATA_W  fetch read data.
- m1_req  in  1  debug read request.
- m1_addr  in  ADDR_W  debug byte address.
- m1_gnt  out  1  debug granted this cycle (combinational).
- m1_rvalid  out  1  debug read data valid (registered).
- m1_rdata  out  DATA_W  debug read data.
- m1_err  out  1  debug misaligned-address error, valid with m1_rvalid.
- rom_ce  out  1  ROM chip enable, active-high.
- rom_addr  out  ADDR_W  ROM byte address.
- rom_inst  in  DATA_W  ROM combinational read data.
- stallreq_if  out  1  fetch stall request: m0_req & ~m0_gnt.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: starve_cnt=0, m0_rvalid=0, m1_rvalid=0, m0_rdata=0, m1_rdata=0, m1_err=0. While rst=1, m0_gnt=m1_gnt=0, rom_ce=0, rom_addr=0, stallreq_if=0.
- Arbitration (combinational, every cycle):
  - If starve_cnt==STARVE_LIMIT and m1_req=1: m1_gnt=1, m0_gnt=0.
  - Else if m0_req=1: m0_gnt=1.
  - Else if m1_req=1: m1_gnt=1.
  - At most one grant per cycle.
- ROM drive:
  - rom_ce = (m0_gnt | m1_gnt) & ~m1_misaligned_grant.
  - rom_addr = address of the granted master, or 0 if none.
  - m1 misaligned means m1_addr[1:0]!=0.
- Response, registered at the next rising edge (latency 1):
  - Granted master: rvalid=1, rdata=rom_inst.
  - Non-granted master: rvalid=0, rdata holds its last value.
  - m1 misaligned grant: m1_rvalid=1, m1_rdata=0, m1_err=1, no ROM access.
  - m1_err=0 on every other m1 response.
- Starvation counter:
  - Increments when m1_req=1 and m1_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 when m1_gnt=1 or m1_req=0.
- Back-to-back requests: a master holding req every cycle gets a grant every cycle it wins, so fetch sustains one instruction per cycle when m1 is idle.
- Request retraction: a master may drop req while ungranted; nothing is issued and no response is produced.
- Reset mid-operation: a request granted in the cycle rst rises produces no response. Both rvalids are 0 at the following edge.
- No buffering: requesters hold req/addr until granted. Addresses are sampled only in the grant cycle.
- STARVE_LIMIT==0: m1 wins whenever it requests (m1 fixed priority).

Test Plan:
- Reset: rst=1 for 2 cycles with m0_req=1, m0_addr=0x0 → rom_ce=0, m0_gnt=0, m0_rvalid=0. First cycle after rst=0: m0_gnt=1, rom_addr=0x0. Next edge: m0_rvalid=1, m0_rdata=ROM[0].
- Fetch stream: m0_req=1 with addr 0x0, 0x4, 0x8, m1 idle → m0_gnt=1 each cycle. m0_rdata follows ROM[0], ROM[1], ROM[2] one cycle later. stallreq_if=0 throughout.
- Starvation, STARVE_LIMIT=4: m0_req and m1_req held, m1_addr=0x10 → m0 wins 4 cycles (starve_cnt 1..4). Cycle 5: m1_gnt=1, stallreq_if=1. Next edge: m1_rvalid=1, m1_rdata=ROM[4]. starve_cnt returns to 0 and m0 wins again.
- Misaligned debug read: m1_addr=0x6, m0 idle → m1_gnt=1, rom_ce=0. Next edge: m1_rvalid=1, m1_err=1, m1_rdata=0.
- Retraction: m1_req high 2 cycles under m0 contention, then dropped → no m1_rvalid, starve_cnt=0.
- Reset mid-grant: rst=1 in a cycle with m0_gnt=1 → m0_rvalid=0 at the next edge, all counters 0.
